buzz_timer: RTL
===============

# buzz_timer

Answer-countdown timer for the Jeopardy board. Counts down whole seconds from a programmable start value and presents the remaining time as two BCD digits. Each digit is a 4-bit nibble that drives one hex-to-seven-segment decoder instance directly. Game control starts, holds (player buzzed in) and clears the timer, and consumes the single-cycle `done` pulse when time runs out.

## Interface
- `CLK_HZ`, 50_000_000 — clock cycles per second; legal range 2 and up.
- `START_SEC`, 10 — reload value in seconds; legal range 1..99, elaboration error otherwise.
- `WARN_SEC`, 3 — warning threshold in seconds; used only when the warning feature is compiled in.
- `clk` in 1 — single system clock; all state on its rising edge.
- `resetn` in 1 — asynchronous, active-low reset.
- `start` in 1 — one-cycle pulse: reload `START_SEC` and run.
- `hold` in 1 — level: freeze the countdown while high.
- `clear` in 1 — one-cycle pulse: stop and zero the display.
- `tens` out 4 — BCD tens digit, 0..9, registered.
- `ones` out 4 — BCD ones digit, 0..9, registered.
- `running` out 1 — high in RUN state, including while held.
- `done` out 1 — one-cycle pulse when the count reaches 00.
- `expired` out 1 — level, high in EXPIRED state.
- `warn` out 1 — blinking low-time indicator.

## Operation
- States:
  - IDLE: reset state, digits 00.
  - RUN: counting down.
  - EXPIRED: reached 00, digits frozen at 00.
- Input priority in a single cycle: `clear` > `start` > `hold`.
- `clear`, any state: go to IDLE, digits 00, prescaler reloaded to CLK_HZ-1. `done` is not asserted.
- `start`, any state including RUN and EXPIRED: digits load `START_SEC` (tens = START_SEC/10, ones = START_SEC%10), prescaler loads CLK_HZ-1, go to RUN. This also applies when `hold` is high in the same cycle.
- RUN with `hold` high: prescaler and digits frozen; state stays RUN.
- RUN with `hold` low:
  - Prescaler decrements each cycle.
  - When the prescaler is 0, it reloads CLK_HZ-1 and the digits decrement in BCD: ones 0 → ones 9 with tens-1; otherwise ones-1.
  - When that decrement produces 00, the state goes to EXPIRED and `done` is high for exactly the next cycle.
- EXPIRED: holds until `start` or `clear`; `hold` is ignored.
- IDLE: `hold` is ignored; digits stay 00.
- Digits never take values above 9 and never wrap below 00.

## Timing
- Reset values: state IDLE, `tens`=0, `ones`=0, `running`=0, `done`=0, `expired`=0, `warn`=0, prescaler CLK_HZ-1.
- `start` sampled at edge N: digits show `START_SEC` and `running`=1 after edge N.
- First decrement at edge N+CLK_HZ; each later decrement follows CLK_HZ unheld cycles after the previous one.
- Each cycle with `hold` high stretches the current second by exactly one cycle.
- Final decrement at edge N+START_SEC·CLK_HZ, counting no hold cycles: digits 00, `running`=0, `expired`=1 and `done`=1 all after that edge; `done` falls after the following edge.
- `clear` or `start` sampled on the same edge as the final decrement wins: no `done` pulse.

## Configuration
- Macro: `BUZZ_TIMER_WARN_EN`.
- Defined: `warn` = RUN, remaining seconds ≤ WARN_SEC and prescaler ≥ CLK_HZ/2 (on for the first half of each second). `warn` is registered and is 0 while held.
- Undefined: `warn` tied to 0 and no comparison logic is built. The port remains so that top-level wiring is unchanged.

## Structure
- Shared package `jeopardy_pkg`:
  - Timer state enum {IDLE, RUN, EXPIRED}.
  - 4-bit BCD digit typedef.
  - Function converting 0..99 to a tens/ones pair.
- Sub-module `sec_prescaler`: the CLK_HZ cycle down-counter with reload and enable inputs and a one-cycle `tick` output. The FSM and BCD digit logic stay in `buzz_timer`.

## Test plan
- Bench parameters: CLK_HZ=4, START_SEC=3, warning feature defined with WARN_SEC=1.
- Reset, then `start` at edge 0:
  - Digits 03 after edge 0; 02 at edge 4; 01 at edge 8; 00 at edge 12.
  - `done` high for only the cycle after edge 12; `expired`=1 and `running`=0 from then on.
- `start`, then `hold` high for 5 cycles starting at cycle 2: the first decrement moves from edge 4 to edge 9.
- `clear` asserted in the same cycle as the final decrement: digits 00, state IDLE, `done` never asserted.
- `start` while at 01 in RUN: digits reload to 03 and a full second elapses before 02.
- `resetn` low mid-count at digits 02, released after 3 cycles: all outputs return to reset values, and a following `start` counts 03→00 normally.
- BCD borrow with START_SEC=10: 10 → 09 at edge 4, with no A–F values ever seen on `tens` or `ones`. With the warning feature, `warn` toggles 1,1,0,0 while the count shows 01.

Source files
------------

// File: rtl/jeopardy_pkg.sv
// Shared types and helpers for the Jeopardy board timing blocks.
//   timer_state_t : answer-timer state encoding (IDLE, RUN, EXPIRED)
//   bcd_t         : one BCD digit, drives a hex-to-seven-segment decoder
//   bcd_pair_t    : tens/ones digit pair
//   to_bcd()      : 0..99 -> tens/ones pair
//   cnt_width()   : register width for a 0..hz-1 down-counter
package jeopardy_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        RUN     = 2'd1,
        EXPIRED = 2'd2
    } timer_state_t;

    typedef logic [3:0] bcd_t;

    typedef struct packed {
        bcd_t tens;
        bcd_t ones;
    } bcd_pair_t;

    function automatic bcd_pair_t to_bcd(input int unsigned value);
        bcd_pair_t pair;
        pair.tens = bcd_t'((value / 10) % 10);
        pair.ones = bcd_t'(value % 10);
        return pair;
    endfunction

    function automatic int cnt_width(input int hz);
        return (hz > 2) ? $clog2(hz) : 1;
    endfunction

endpackage

// File: rtl/sec_prescaler.sv
// One-second prescaler: down-counter from CLK_HZ-1 to 0.
//   clk, resetn  : system clock, async active-low reset (count resets to CLK_HZ-1)
//   i_reload     : reload CLK_HZ-1 (wins over i_en)
//   i_en         : count down this cycle
//   o_tick       : high in the enabled cycle where the count is 0 (count reloads)
//   o_cnt_nxt    : count value after the next edge; only present when
//                  BUZZ_TIMER_WARN_EN is defined (feeds the warning blink)
module sec_prescaler
    import jeopardy_pkg::*;
#(
    parameter int CLK_HZ = 50_000_000
) (
    input  logic clk,
    input  logic resetn,
    input  logic i_reload,
    input  logic i_en,
    output logic o_tick
`ifdef BUZZ_TIMER_WARN_EN
    ,
    output logic [cnt_width(CLK_HZ)-1:0] o_cnt_nxt
`endif
);

    localparam int CW = cnt_width(CLK_HZ);
    localparam logic [CW-1:0] RELOAD = CW'(CLK_HZ - 1);

    logic [CW-1:0] r_cnt;
    logic [CW-1:0] w_cnt_nxt;
    logic          w_zero;

    assign w_zero = (r_cnt == '0);

    always_comb begin
        w_cnt_nxt = r_cnt;
        if (i_reload) begin
            w_cnt_nxt = RELOAD;
        end else if (i_en) begin
            w_cnt_nxt = w_zero ? RELOAD : (r_cnt - 1'b1);
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_cnt <= RELOAD;
        end else begin
            r_cnt <= w_cnt_nxt;
        end
    end

    assign o_tick = i_en & ~i_reload & w_zero;

`ifdef BUZZ_TIMER_WARN_EN
    assign o_cnt_nxt = w_cnt_nxt;
`endif

endmodule

// File: rtl/buzz_timer.sv
// Answer-countdown timer: counts whole seconds down from START_SEC and shows
// the remaining time as two registered BCD digits.
//   clk, resetn : system clock, async active-low reset
//   start       : pulse, reload START_SEC and run (any state)
//   hold        : level, freeze the countdown while in RUN
//   clear       : pulse, stop and show 00 (highest priority)
//   tens, ones  : BCD digits 0..9
//   running     : high in RUN (also while held)
//   done        : one-cycle pulse after the count reaches 00
//   expired     : high in EXPIRED
//   warn        : blinking low-time indicator; built only when the macro
//                 BUZZ_TIMER_WARN_EN is defined, otherwise tied to 0
//
// state   | meaning
// IDLE    | reset/cleared, digits 00
// RUN     | counting down (frozen while hold is high)
// EXPIRED | reached 00, digits frozen until start or clear
module buzz_timer
    import jeopardy_pkg::*;
#(
    parameter int CLK_HZ    = 50_000_000,
    parameter int START_SEC = 10,
    parameter int WARN_SEC  = 3
) (
    input  logic       clk,
    input  logic       resetn,
    input  logic       start,
    input  logic       hold,
    input  logic       clear,
    output logic [3:0] tens,
    output logic [3:0] ones,
    output logic       running,
    output logic       done,
    output logic       expired,
    output logic       warn
);

    if (CLK_HZ < 2) begin : g_bad_clk_hz
        $error("buzz_timer: CLK_HZ must be at least 2");
    end
    if (START_SEC < 1 || START_SEC > 99) begin : g_bad_start_sec
        $error("buzz_timer: START_SEC must be in 1..99");
    end
    if (WARN_SEC < 0 || WARN_SEC > 99) begin : g_bad_warn_sec
        $error("buzz_timer: WARN_SEC must be in 0..99");
    end

    localparam bcd_pair_t START_BCD = to_bcd(START_SEC);

    timer_state_t r_state;
    timer_state_t w_state_nxt;
    bcd_t         r_tens;
    bcd_t         r_ones;
    bcd_t         w_tens_nxt;
    bcd_t         w_ones_nxt;
    logic         r_done;
    logic         w_done_nxt;
    logic         w_reload;
    logic         w_en;
    logic         w_tick;

    // Prescaler control kept outside the FSM process so the tick feedback
    // does not form a loop through one combinational block.
    assign w_reload = clear | start;
    assign w_en     = (r_state == RUN) & ~hold & ~clear & ~start;

`ifdef BUZZ_TIMER_WARN_EN
    localparam int CW = cnt_width(CLK_HZ);
    logic [CW-1:0] w_cnt_nxt;
`endif

    sec_prescaler #(
        .CLK_HZ(CLK_HZ)
    ) u_prescaler (
        .clk      (clk),
        .resetn   (resetn),
        .i_reload (w_reload),
        .i_en     (w_en),
        .o_tick   (w_tick)
`ifdef BUZZ_TIMER_WARN_EN
        ,
        .o_cnt_nxt(w_cnt_nxt)
`endif
    );

    always_comb begin
        w_state_nxt = r_state;
        w_tens_nxt  = r_tens;
        w_ones_nxt  = r_ones;
        w_done_nxt  = 1'b0;
        if (clear) begin
            w_state_nxt = IDLE;
            w_tens_nxt  = '0;
            w_ones_nxt  = '0;
        end else if (start) begin
            w_state_nxt = RUN;
            w_tens_nxt  = START_BCD.tens;
            w_ones_nxt  = START_BCD.ones;
        end else begin
            case (r_state)
                RUN: begin
                    if (w_tick) begin
                        if (r_ones == 4'd0) begin
                            w_ones_nxt = 4'd9;
                            w_tens_nxt = r_tens - 4'd1;
                        end else begin
                            w_ones_nxt = r_ones - 4'd1;
                        end
                        // Only 01 can step to 00, so the count never wraps.
                        if (r_tens == 4'd0 && r_ones == 4'd1) begin
                            w_state_nxt = EXPIRED;
                            w_done_nxt  = 1'b1;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_state <= IDLE;
            r_tens  <= '0;
            r_ones  <= '0;
            r_done  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_tens  <= w_tens_nxt;
            r_ones  <= w_ones_nxt;
            r_done  <= w_done_nxt;
        end
    end

    assign tens    = r_tens;
    assign ones    = r_ones;
    assign running = (r_state == RUN);
    assign expired = (r_state == EXPIRED);
    assign done    = r_done;

`ifdef BUZZ_TIMER_WARN_EN
    // Evaluated on next-cycle values so the registered blink lines up with
    // the digits: on for the first half of each displayed second.
    logic [6:0] w_secs_nxt;
    logic       w_held;
    logic       w_warn_nxt;
    logic       r_warn;

    assign w_secs_nxt = 7'(w_tens_nxt) * 7'd10 + 7'(w_ones_nxt);
    assign w_held     = (r_state == RUN) & hold & ~clear & ~start;
    assign w_warn_nxt = (w_state_nxt == RUN) & ~w_held
                      & (w_secs_nxt <= 7'(WARN_SEC))
                      & (w_cnt_nxt >= CW'(CLK_HZ / 2));

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_warn <= 1'b0;
        end else begin
            r_warn <= w_warn_nxt;
        end
    end

    assign warn = r_warn;
`else
    assign warn = 1'b0;
`endif

endmodule
